// File: rtl/gpio_sevenseg_mux.sv
// gpio_sevenseg_mux: time-multiplexed seven-segment driver for NUM_DIGITS hex
// digits with per-digit decimal point, enable mask, PWM brightness and a
// one-cycle anti-ghosting guard at the start of every digit slot.
// Inputs are captured into shadow registers once per scan frame.
// Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking.
module gpio_sevenseg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE_W     = 16,
    parameter int BRIGHT_W       = 4,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [PRESCALE_W-1:0]   p;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic                    load_pending;

    logic                    slot_end;
    logic                    snapshot;
    logic [NUM_DIGITS-1:0]   en_next;
    logic [3:0]              nib;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [7:0]              seg_on;

    // Hex nibble to {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        hex_to_seg = 7'h00;
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            4'hF: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign slot_end = (p == {PRESCALE_W{1'b1}});
    // A pending load (set by reset) forces a snapshot on the very first clock.
    assign snapshot = (slot_end && (idx == LAST_IDX)) || load_pending;

    // Enable mask to capture at snapshot, optionally with leading zeros blanked.
    always_comb begin
        en_next = digit_en_i;
`ifdef SEVENSEG_LZB_EN
        begin
            logic blanking;
            blanking = 1'b1;
            // Walk from the most significant digit down; digit 0 always stays.
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (blanking && (value_i[4*k +: 4] == 4'h0) && !dp_i[k]) begin
                    en_next[k] = 1'b0;
                end else begin
                    blanking = 1'b0;
                end
            end
        end
`endif
    end

    // Prescaler and digit index: one slot per 2^PRESCALE_W clocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p   <= '0;
            idx <= '0;
        end else begin
            p <= p + 1'b1;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow registers: refreshed once per frame so a scan never shows mixed data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            load_pending <= 1'b1;
            frame_o      <= 1'b0;
        end else begin
            frame_o <= snapshot;
            if (snapshot) begin
                shadow_value <= value_i;
                shadow_dp    <= dp_i;
                shadow_en    <= en_next;
                load_pending <= 1'b0;
            end
        end
    end

    // Anode/segment selection for the current (p, idx); p==0 is the guard cycle.
    always_comb begin
        nib    = shadow_value[{idx, 2'b00} +: 4];
        lit    = shadow_en[idx] && (p != '0) && (p[PRESCALE_W-1 -: BRIGHT_W] <= bright_i);
        an_on  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_on[k] = lit && (idx == IDX_W'(k));
        end
        seg_on = shadow_en[idx] ? {shadow_dp[idx], hex_to_seg(nib)} : 8'h00;
    end

    // Output register with board polarity applied; reset drives pins inactive at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
        end else begin
            an_o  <= AN_ACTIVE_LOW ? ~an_on : an_on;
            seg_o <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        end
    end

endmodule

// File: tb/tb_gpio_sevenseg_mux.sv
// Bench for gpio_sevenseg_mux: NUM_DIGITS=4, PRESCALE_W=4 (16-clock slots),
// BRIGHT_W=2, active-low anodes and segments. Table of per-frame vectors plus
// hand-written sequences for reset, mid-frame snapshot and async reset.
module tb_gpio_sevenseg_mux;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = '0;
    logic [1:0]  bright = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [1:0]  bright;
        logic [31:0] segs;     // {d3,d2,d1,d0} expected seg_o per slot
        logic [3:0]  exp_en;   // digits expected to light
        int          on_cnt;   // lit cycles per enabled slot
    } vec_t;

    vec_t vecs[7];
    int   num_vecs;

    always #5 clk = ~clk;

    gpio_sevenseg_mux #(
        .NUM_DIGITS(ND),
        .PRESCALE_W(4),
        .BRIGHT_W(2),
        .AN_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .value_i(value),
        .dp_i(dp),
        .digit_en_i(en),
        .bright_i(bright),
        .seg_o(seg),
        .an_o(an),
        .frame_o(frame)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge where frame_o is high (snapshot on the edge before).
    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: no frame_o pulse within 200 cycles, expected one", name);
        end
    endtask

    // Checks the 64 output cycles following a frame_o pulse, one slot per digit.
    task automatic observe_frame(input string name, input logic [3:0] den, input int on_cnt);
        int         frames;
        int         bad;
        int         bad_p;
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        logic [3:0] bad_an;
        logic [7:0] bad_seg;
        logic [3:0] bad_exp_an;
        frames = 0;
        for (int d = 0; d < ND; d++) begin
            bad        = 0;
            bad_p      = 0;
            bad_an     = '0;
            bad_seg    = '0;
            bad_exp_an = '0;
            exp_seg    = exp_q.pop_front();
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                exp_an = 4'hF;
                if (den[d] && s >= 1 && s <= on_cnt) exp_an[d] = 1'b0;
                if (frame === 1'b1) frames++;
                if (an !== exp_an || seg !== exp_seg) begin
                    if (bad == 0) begin
                        bad_p      = s;
                        bad_an     = an;
                        bad_seg    = seg;
                        bad_exp_an = exp_an;
                    end
                    bad++;
                end
            end
            n_vec++;
            if (bad != 0) begin
                n_miss++;
                $display("FAIL %s digit %0d: %0d bad cycles, first at p=%0d an=%b seg=%h, expected an=%b seg=%h",
                         name, d, bad, bad_p, bad_an, bad_seg, bad_exp_an, exp_seg);
            end
        end
        check({name, " frame_count"}, frames, 1);
    endtask

    task automatic push_segs(input logic [31:0] segs);
        for (int d = 0; d < ND; d++) exp_q.push_back(segs[8*d +: 8]);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b1111, 2'd3, 32'hF9A4_B099, 4'b1111, 15};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b1111, 2'd0, 32'h8883_C6A1, 4'b1111, 3};
        vecs[2] = '{16'h1234, 4'b0100, 4'b1011, 2'd3, 32'hF9FF_B099, 4'b1011, 15};
        vecs[3] = '{16'h5678, 4'b1001, 4'b1111, 2'd1, 32'h1282_F800, 4'b1111, 7};
        vecs[4] = '{16'h90EF, 4'b0010, 4'b1111, 2'd2, 32'h90C0_068E, 4'b1111, 11};
`ifdef SEVENSEG_LZB_EN
        vecs[5] = '{16'h0050, 4'b0000, 4'b1111, 2'd3, 32'hFFFF_92C0, 4'b0011, 15};
        vecs[6] = '{16'h0000, 4'b0000, 4'b1111, 2'd3, 32'hFFFF_FFC0, 4'b0001, 15};
        num_vecs = 7;
`else
        vecs[5] = '{16'h0050, 4'b0000, 4'b1111, 2'd3, 32'hC0C0_92C0, 4'b1111, 15};
        num_vecs = 6;
`endif

        // Reset state
        rst    = 1'b1;
        value  = 16'h1234;
        dp     = 4'b0000;
        en     = 4'hF;
        bright = 2'd3;
        repeat (3) @(negedge clk);
        check("reset an_o", an, 4'hF);
        check("reset seg_o", seg, 8'hFF);
        check("reset frame_o", frame, 1'b0);

        // First snapshot on the first clock after release, guard cycle first
        rst = 1'b0;
        @(negedge clk);
        check("first frame_o", frame, 1'b1);
        check("first guard an_o", an, 4'hF);
        @(negedge clk);
        check("first digit0 an_o", an, 4'hE);
        check("first digit0 seg_o", seg, 8'h99);

        // Table-driven frames
        for (int v = 0; v < num_vecs; v++) begin
            value  = vecs[v].value;
            dp     = vecs[v].dp;
            en     = vecs[v].en;
            bright = vecs[v].bright;
            push_segs(vecs[v].segs);
            wait_frame($sformatf("vec%0d wait", v));
            observe_frame($sformatf("vec%0d", v), vecs[v].exp_en, vecs[v].on_cnt);
        end

        // Mid-frame value change is held off until the next snapshot
        value  = 16'h1234;
        dp     = 4'b0000;
        en     = 4'hF;
        bright = 2'd3;
        wait_frame("snap setup");
        begin
            int frames;
            frames = 0;
            repeat (20) @(negedge clk);
            value = 16'hABCD;
            for (int j = 21; j <= 64; j++) begin
                @(negedge clk);
                if (frame === 1'b1) frames++;
                if (j == 40) begin
                    check("snap digit2 an_o", an, 4'hB);
                    check("snap digit2 seg_o", seg, 8'hA4);
                end
                if (j == 56) begin
                    check("snap digit3 an_o", an, 4'h7);
                    check("snap digit3 seg_o", seg, 8'hF9);
                end
            end
            check("snap frame_count", frames, 1);
        end
        push_segs(32'h8883_C6A1);
        observe_frame("snap next", 4'hF, 15);

        // Async reset in the middle of digit 2's slot
        value = 16'h1234;
        wait_frame("rst setup");
        repeat (40) @(negedge clk);
        check("pre-reset digit2 an_o", an, 4'hB);
        #2 rst = 1'b1;
        #1;
        check("async reset an_o", an, 4'hF);
        check("async reset seg_o", seg, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart frame_o", frame, 1'b1);
        check("restart guard an_o", an, 4'hF);
        @(negedge clk);
        check("restart digit0 an_o", an, 4'hE);
        check("restart digit0 seg_o", seg, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
